// File: rtl/nest_pkg.sv
// Shared definitions for the keyword-nesting checker: kind and error encodings,
// ASCII class constants, keyword strings and character helpers.
package nest_pkg;

  localparam logic [1:0] KIND_BEGIN = 2'd0;
  localparam logic [1:0] KIND_CASE  = 2'd1;
  localparam logic [1:0] KIND_FORK  = 2'd2;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_UNDER    = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_OVER     = 2'd3;

  localparam logic [7:0] CH_UP_A  = 8'h41;
  localparam logic [7:0] CH_UP_Z  = 8'h5A;
  localparam logic [7:0] CH_LO_A  = 8'h61;
  localparam logic [7:0] CH_LO_Z  = 8'h7A;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_US    = 8'h5F;
  localparam logic [7:0] CASE_BIT = 8'h20;

  // Keywords are right-aligned: the last character sits in the low byte.
  localparam logic [55:0] KW_BEGIN   = {16'h0, "begin"};
  localparam logic [55:0] KW_END     = {32'h0, "end"};
  localparam logic [55:0] KW_CASE    = {24'h0, "case"};
  localparam logic [55:0] KW_ENDCASE = "endcase";
  localparam logic [55:0] KW_FORK    = {24'h0, "fork"};
  localparam logic [55:0] KW_JOIN    = {24'h0, "join"};

  localparam int LEN_BEGIN   = 5;
  localparam int LEN_END     = 3;
  localparam int LEN_CASE    = 4;
  localparam int LEN_ENDCASE = 7;
  localparam int LEN_FORK    = 4;
  localparam int LEN_JOIN    = 4;

  function automatic logic is_word_char(input logic [7:0] c);
    return ((c >= CH_UP_A) && (c <= CH_UP_Z)) || ((c >= CH_LO_A) && (c <= CH_LO_Z)) ||
           ((c >= CH_0) && (c <= CH_9)) || (c == CH_US);
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return ((c >= CH_UP_A) && (c <= CH_UP_Z)) ? (c | CASE_BIT) : c;
  endfunction

endpackage

// File: rtl/nest_kw_decode.sv
// Combinational keyword classifier: maps the buffered word to opener/closer
// flags and the keyword-pair kind.
module nest_kw_decode
  import nest_pkg::*;
#(
  parameter int MAXLEN = 8,
  localparam int LW = $clog2(MAXLEN + 1)
) (
  input  logic [8*MAXLEN-1:0] word,
  input  logic [LW-1:0]       len,
  input  logic                overlong,
  output logic                is_open,
  output logic                is_close,
  output logic [1:0]          kind
);

  // Buffer byte i holds the i-th character of the word.
  function automatic logic kw_match(input logic [8*MAXLEN-1:0] w, input logic [LW-1:0] l,
                                    input logic [55:0] kw, input int kw_len);
    logic m;
    m = (int'(l) == kw_len);
    for (int i = 0; i < MAXLEN; i++) begin
      m = m & ((i >= kw_len) || (8'(w >> (8 * i)) == 8'(kw >> (8 * (kw_len - 1 - i)))));
    end
    return m;
  endfunction

  // Classify the buffered word; overlong words are never keywords.
  always_comb begin
    is_open  = 1'b0;
    is_close = 1'b0;
    kind     = KIND_BEGIN;
    if (overlong) begin
      is_open = 1'b0;
    end else if (kw_match(word, len, KW_BEGIN, LEN_BEGIN)) begin
      is_open = 1'b1;
      kind    = KIND_BEGIN;
    end else if (kw_match(word, len, KW_CASE, LEN_CASE)) begin
      is_open = 1'b1;
      kind    = KIND_CASE;
    end else if (kw_match(word, len, KW_FORK, LEN_FORK)) begin
      is_open = 1'b1;
      kind    = KIND_FORK;
    end else if (kw_match(word, len, KW_END, LEN_END)) begin
      is_close = 1'b1;
      kind     = KIND_BEGIN;
    end else if (kw_match(word, len, KW_ENDCASE, LEN_ENDCASE)) begin
      is_close = 1'b1;
      kind     = KIND_CASE;
    end else if (kw_match(word, len, KW_JOIN, LEN_JOIN)) begin
      is_close = 1'b1;
      kind     = KIND_FORK;
    end else begin
      is_close = 1'b0;
    end
  end

endmodule

// File: rtl/nest_checker.sv
// Streaming begin/end, case/endcase, fork/join nesting checker with a kind
// stack, sticky error code and a combinational "balanced" lookahead.
module nest_checker
  import nest_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int MAXLEN = 8,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in,
  output logic          result,
  output logic [DW-1:0] depth,
  output logic          error,
  output logic [1:0]    err_code
);

  localparam int LW = $clog2(MAXLEN + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [8*MAXLEN-1:0] word_r;
  logic [LW-1:0]       len_r;
  logic                overlong_r;
  logic [1:0]          stack_r [DEPTH];
  logic [DW-1:0]       depth_r;
  logic                error_r;
  logic [1:0]          err_code_r;

  logic       is_word_s, commit_s, kw_open_s, kw_close_s;
  logic [1:0] kw_kind_s, top_s, err_val_s;
  logic       push_s, pop_s, err_set_s, result_s;

  assign is_word_s = is_word_char(in);
  assign commit_s  = in_valid & ~is_word_s & (len_r != {LW{1'b0}});

  // One decoder serves both the commit path and the result lookahead.
  nest_kw_decode #(.MAXLEN(MAXLEN)) u_decode (
    .word     (word_r),
    .len      (len_r),
    .overlong (overlong_r),
    .is_open  (kw_open_s),
    .is_close (kw_close_s),
    .kind     (kw_kind_s)
  );

  // Kind currently on top of the stack.
  always_comb begin
    top_s = KIND_BEGIN;
    if (depth_r != {DW{1'b0}}) begin
      top_s = stack_r[PW'(depth_r - DW'(1))];
    end else begin
      top_s = KIND_BEGIN;
    end
  end

  // Stack action decided when a word is committed.
  always_comb begin
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
    err_val_s = ERR_NONE;
    if (commit_s && !error_r) begin
      if (kw_open_s) begin
        if (depth_r < DW'(DEPTH)) begin
          push_s = 1'b1;
        end else begin
          err_set_s = 1'b1;
          err_val_s = ERR_OVER;
        end
      end else if (kw_close_s) begin
        if (depth_r == {DW{1'b0}}) begin
          err_set_s = 1'b1;
          err_val_s = ERR_UNDER;
        end else if (kw_kind_s == top_s) begin
          pop_s = 1'b1;
        end else begin
          err_set_s = 1'b1;
          err_val_s = ERR_MISMATCH;
        end
      end else begin
        push_s = 1'b0;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Word buffer: lowercase accumulation, overlong detection, clear on delimiter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_r     <= {(8*MAXLEN){1'b0}};
      len_r      <= {LW{1'b0}};
      overlong_r <= 1'b0;
    end else if (in_valid) begin
      if (is_word_s) begin
        if (len_r < LW'(MAXLEN)) begin
          word_r[8*len_r +: 8] <= to_lower(in);
          len_r                <= len_r + LW'(1);
        end else begin
          overlong_r <= 1'b1;
        end
      end else begin
        word_r     <= {(8*MAXLEN){1'b0}};
        len_r      <= {LW{1'b0}};
        overlong_r <= 1'b0;
      end
    end
  end

  // Committed depth and sticky error state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_r    <= {DW{1'b0}};
      error_r    <= 1'b0;
      err_code_r <= ERR_NONE;
    end else if (push_s) begin
      depth_r <= depth_r + DW'(1);
    end else if (pop_s) begin
      depth_r <= depth_r - DW'(1);
    end else if (err_set_s) begin
      error_r    <= 1'b1;
      err_code_r <= err_val_s;
    end
  end

  // Stack storage is deliberately left unreset; depth alone defines validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_r[PW'(depth_r)] <= kw_kind_s;
    end
  end

  // Lookahead treating the pending word as already terminated.
  always_comb begin
    result_s = 1'b0;
    if (error_r) begin
      result_s = 1'b0;
    end else if (kw_open_s) begin
      result_s = 1'b0;
    end else if (kw_close_s) begin
      result_s = (depth_r == DW'(1)) && (kw_kind_s == top_s);
    end else begin
      result_s = (depth_r == {DW{1'b0}});
    end
  end

  assign result   = result_s;
  assign depth    = depth_r;
  assign error    = error_r;
  assign err_code = err_code_r;

endmodule

// File: tb/tb_nest_checker.sv
// Directed-vector bench for nest_checker: a DEPTH=16 instance plus a DEPTH=4
// instance sharing the same character feed.
module tb_nest_checker;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_b;

  logic       result16, error16;
  logic [4:0] depth16;
  logic [1:0] code16;
  logic       result4, error4;
  logic [2:0] depth4;
  logic [1:0] code4;

  int n_checks;
  int n_fails;

  nest_checker #(.DEPTH(16), .MAXLEN(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_b),
    .result(result16), .depth(depth16), .error(error16), .err_code(code16)
  );

  nest_checker #(.DEPTH(4), .MAXLEN(8)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_b),
    .result(result4), .depth(depth4), .error(error4), .err_code(code4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] c);
    in_b     = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    n_checks++; if (depth16 !== 5'd0) begin $display("FAIL reset_depth got %0d want 0", depth16); n_fails++; end
    n_checks++; if (error16 !== 1'b0) begin $display("FAIL reset_error got %0b want 0", error16); n_fails++; end
    n_checks++; if (code16 !== 2'd0) begin $display("FAIL reset_code got %0d want 0", code16); n_fails++; end
    n_checks++; if (result16 !== 1'b1) begin $display("FAIL reset_result got %0b want 1", result16); n_fails++; end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_begin_end();
    do_reset();
    send_str("begin ");
    n_checks++; if (depth16 !== 5'd1) begin $display("FAIL be_depth1 got %0d want 1", depth16); n_fails++; end
    n_checks++; if (result16 !== 1'b0) begin $display("FAIL be_result_open got %0b want 0", result16); n_fails++; end
    send_str("end");
    n_checks++; if (result16 !== 1'b1) begin $display("FAIL be_lookahead got %0b want 1", result16); n_fails++; end
    n_checks++; if (depth16 !== 5'd1) begin $display("FAIL be_depth_pending got %0d want 1", depth16); n_fails++; end
    send_byte(8'h20);
    n_checks++; if (depth16 !== 5'd0) begin $display("FAIL be_depth0 got %0d want 0", depth16); n_fails++; end
    n_checks++; if (result16 !== 1'b1) begin $display("FAIL be_result got %0b want 1", result16); n_fails++; end
    n_checks++; if (code16 !== 2'd0) begin $display("FAIL be_code got %0d want 0", code16); n_fails++; end
  endtask

  task automatic test_mixed_case();
    do_reset();
    send_str("BeGiN case ");
    n_checks++; if (depth16 !== 5'd2) begin $display("FAIL mc_peak got %0d want 2", depth16); n_fails++; end
    send_str("ENDCASE");
    n_checks++; if (result16 !== 1'b0) begin $display("FAIL mc_lookahead got %0b want 0", result16); n_fails++; end
    send_byte(8'h20);
    n_checks++; if (depth16 !== 5'd1) begin $display("FAIL mc_depth1 got %0d want 1", depth16); n_fails++; end
    send_str("End ");
    n_checks++; if (depth16 !== 5'd0) begin $display("FAIL mc_depth0 got %0d want 0", depth16); n_fails++; end
    n_checks++; if (result16 !== 1'b1) begin $display("FAIL mc_result got %0b want 1", result16); n_fails++; end
    n_checks++; if (error16 !== 1'b0) begin $display("FAIL mc_error got %0b want 0", error16); n_fails++; end
  endtask

  task automatic test_mismatch();
    do_reset();
    send_str("begin endcase ");
    n_checks++; if (error16 !== 1'b1) begin $display("FAIL mm_error got %0b want 1", error16); n_fails++; end
    n_checks++; if (code16 !== 2'd2) begin $display("FAIL mm_code got %0d want 2", code16); n_fails++; end
    n_checks++; if (depth16 !== 5'd1) begin $display("FAIL mm_depth got %0d want 1", depth16); n_fails++; end
    n_checks++; if (result16 !== 1'b0) begin $display("FAIL mm_result got %0b want 0", result16); n_fails++; end
    send_str("end ");
    n_checks++; if (error16 !== 1'b1) begin $display("FAIL mm_sticky_error got %0b want 1", error16); n_fails++; end
    n_checks++; if (code16 !== 2'd2) begin $display("FAIL mm_sticky_code got %0d want 2", code16); n_fails++; end
    n_checks++; if (depth16 !== 5'd1) begin $display("FAIL mm_frozen_depth got %0d want 1", depth16); n_fails++; end
    n_checks++; if (result16 !== 1'b0) begin $display("FAIL mm_sticky_result got %0b want 0", result16); n_fails++; end
  endtask

  task automatic test_underflow();
    do_reset();
    send_str("end ");
    n_checks++; if (error16 !== 1'b1) begin $display("FAIL uf_error got %0b want 1", error16); n_fails++; end
    n_checks++; if (code16 !== 2'd1) begin $display("FAIL uf_code got %0d want 1", code16); n_fails++; end
    n_checks++; if (depth16 !== 5'd0) begin $display("FAIL uf_depth got %0d want 0", depth16); n_fails++; end
    n_checks++; if (result16 !== 1'b0) begin $display("FAIL uf_result got %0b want 0", result16); n_fails++; end
  endtask

  task automatic test_overflow();
    do_reset();
    send_str("fork fork fork fork ");
    n_checks++; if (depth4 !== 3'd4) begin $display("FAIL of_full_depth got %0d want 4", depth4); n_fails++; end
    n_checks++; if (error4 !== 1'b0) begin $display("FAIL of_full_error got %0b want 0", error4); n_fails++; end
    send_str("fork ");
    n_checks++; if (code4 !== 2'd3) begin $display("FAIL of_code got %0d want 3", code4); n_fails++; end
    n_checks++; if (error4 !== 1'b1) begin $display("FAIL of_error got %0b want 1", error4); n_fails++; end
    n_checks++; if (depth4 !== 3'd4) begin $display("FAIL of_depth got %0d want 4", depth4); n_fails++; end
    n_checks++; if (result4 !== 1'b0) begin $display("FAIL of_result got %0b want 0", result4); n_fails++; end
    n_checks++; if (depth16 !== 5'd5) begin $display("FAIL of_deep16 got %0d want 5", depth16); n_fails++; end
    n_checks++; if (error16 !== 1'b0) begin $display("FAIL of_deep16_error got %0b want 0", error16); n_fails++; end
  endtask

  task automatic test_nonkeywords();
    do_reset();
    send_str("beginx end_ begin2 abcdefghijkl ");
    n_checks++; if (depth16 !== 5'd0) begin $display("FAIL nk_depth got %0d want 0", depth16); n_fails++; end
    n_checks++; if (result16 !== 1'b1) begin $display("FAIL nk_result got %0b want 1", result16); n_fails++; end
    n_checks++; if (error16 !== 1'b0) begin $display("FAIL nk_error got %0b want 0", error16); n_fails++; end
    send_str("begin en");
    in_b = 8'h65;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (depth16 !== 5'd1) begin $display("FAIL idle_depth got %0d want 1", depth16); n_fails++; end
    n_checks++; if (result16 !== 1'b0) begin $display("FAIL idle_result got %0b want 0", result16); n_fails++; end
    send_str("d ");
    n_checks++; if (depth16 !== 5'd0) begin $display("FAIL idle_close got %0d want 0", depth16); n_fails++; end
    n_checks++; if (result16 !== 1'b1) begin $display("FAIL idle_result_end got %0b want 1", result16); n_fails++; end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_str("case fork jo");
    n_checks++; if (depth16 !== 5'd2) begin $display("FAIL ar_pre_depth got %0d want 2", depth16); n_fails++; end
    reset = 1'b0;
    #2;
    n_checks++; if (depth16 !== 5'd0) begin $display("FAIL ar_depth got %0d want 0", depth16); n_fails++; end
    n_checks++; if (error16 !== 1'b0) begin $display("FAIL ar_error got %0b want 0", error16); n_fails++; end
    n_checks++; if (result16 !== 1'b1) begin $display("FAIL ar_result got %0b want 1", result16); n_fails++; end
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_str("begin ");
    n_checks++; if (depth16 !== 5'd1) begin $display("FAIL ar_fresh_depth got %0d want 1", depth16); n_fails++; end
    send_str("end ");
    n_checks++; if (depth16 !== 5'd0) begin $display("FAIL ar_end_depth got %0d want 0", depth16); n_fails++; end
    n_checks++; if (result16 !== 1'b1) begin $display("FAIL ar_end_result got %0b want 1", result16); n_fails++; end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_b     = 8'h00;
    test_reset();
    test_begin_end();
    test_mixed_case();
    test_mismatch();
    test_underflow();
    test_overflow();
    test_nonkeywords();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
